rv32i_single_cycle_core: RTL and testbench
==========================================

Name: rv32i_single_cycle_core

Overview:
- Single-cycle RV32I integer core. Executes one instruction per clock.
- Fetches from an external instruction ROM through rom_addr/instruction.
- Loads and stores 32-bit words through an external data RAM port (mem_*).
- Contains a 32x32 register file. Sits between the rom and ram models at the top of the didactic platform.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded while reset is asserted.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-high reset. Asserted when 1, despite the codebase port name.
- instruction  input  32  instruction word at rom_addr; combinationally valid in the same cycle.
- mem_rd_data  input  32  RAM read word at mem_addr; combinationally valid in the same cycle.
- mem_wr_sig  output  1  RAM write enable; the word is written on the next rising edge.
- mem_wr_data  output  32  store data (rs2 value).
- mem_addr  output  32  RAM byte address (rs1 + imm).
- rom_addr  output  32  current PC, as a byte address.

Behaviour:
- Reset, sampled on a rising edge while reset_n=1:
  - PC <= RESET_PC.
  - All 32 registers <= 0.
  - mem_wr_sig is forced to 0 while reset is asserted; no register write occurs.
- Register file:
  - Must be an instance named register_file_inst holding array registers[0:31], so the bench can dump it.
  - Two combinational read ports and one synchronous write port.
  - x0 reads 0 at all times; writes to x0 are ignored.
  - A write and a read of the same register in one cycle returns the old value (single-cycle design, no bypass needed).
- rom_addr = PC, continuously.
- Next PC:
  - Default PC+4.
  - Taken branch / JAL: PC+imm.
  - JALR: (rs1+imm) & ~1.
  - All arithmetic wraps modulo 2^32. No alignment traps.
- Supported instructions:
  - LUI, AUIPC.
  - JAL, JALR: rd <= PC+4.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Immediates: I/S/B/U/J formats per RV32I, sign-extended from bit 31. Shift amount = low 5 bits.
- SLT/SLTI compare signed; SLTU/SLTIU/BLTU/BGEU compare unsigned. SRA/SRAI replicate the sign bit.
- Memory interface:
  - mem_addr = rs1+imm for loads and stores; it may show the ALU result otherwise.
  - mem_wr_data = rs2 always.
  - mem_wr_sig = 1 only for SW. Word access only; low two address bits are passed through unchanged.
  - LW: rd <= mem_rd_data at the end of the same cycle.
- Any other opcode (including FENCE/ECALL/EBREAK and byte/half loads/stores):
  - Executes as a NOP: PC+4, no register or memory write.
- Reset asserted mid-program: takes effect at the next rising edge and discards the current instruction's writes. Execution restarts at RESET_PC on the first edge after reset_n returns to 0.

Test Plan:
- Reset: hold reset_n=1 for 2 cycles with ROM of NOPs -> rom_addr=0, mem_wr_sig=0, all registers 0. Release -> rom_addr steps 0,4,8.
- ALU:
  - Program: ADDI x1,x0,-5; ADDI x2,x0,3; SUB x3,x1,x2; SLT x4,x1,x2; SLTU x5,x1,x2; SRAI x6,x1,1.
  - Required: x3=0xFFFFFFF8, x4=1, x5=0, x6=0xFFFFFFFD.
  - ADDI x0,x0,7 leaves x0=0.
- Memory: ADDI x1,x0,0x40; ADDI x2,x0,0x123; SW x2,4(x1); LW x3,4(x1):
  - SW cycle: mem_wr_sig=1, mem_addr=0x44, mem_wr_data=0x123.
  - Then x3=0x123.
- Branch/jump, each as a separate program:
  - BEQ x0,x0,+8 at PC 0 -> next rom_addr 8.
  - BNE x0,x0,+8 -> next rom_addr 4.
  - JAL x1,+16 at PC 8 -> x1=12, rom_addr 24.
  - JALR x2,5(x0) -> rom_addr 4.
- Upper immediates: LUI x1,0xABCDE -> x1=0xABCDE000. AUIPC x2,1 at PC 4 -> x2=0x1004.
- Illegal opcode 0x00000000 at PC 0 -> PC advances to 4, registers unchanged, mem_wr_sig=0. Asserting reset mid-program returns rom_addr to 0 on the next edge.

Source files
------------

// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I integer core: one instruction per clock, combinational ROM fetch
// and word-wide RAM access, with a 32x32 register file.

module rv32i_register_file (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < 32; i++) registers[i] <= '0;
        end else if (i_we && (i_waddr != '0)) begin
            registers[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 : registers[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : registers[i_raddr2];
endmodule

module rv32i_single_cycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instruction,
    input  logic [31:0] mem_rd_data,
    output logic        mem_wr_sig,
    output logic [31:0] mem_wr_data,
    output logic [31:0] mem_addr,
    output logic [31:0] rom_addr
);
    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_t;

    logic [31:0] r_pc;
    opcode_t     w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_rs1_val, w_rs2_val, w_alu_b, w_alu, w_pc_plus4, w_addr;
    logic [31:0] w_rd_data, w_next_pc;
    logic        w_rd_we, w_store, w_taken, w_arith_ok, w_sub;

    assign w_opcode   = opcode_t'(instruction[6:0]);
    assign w_f3       = instruction[14:12];
    assign w_f7       = instruction[31:25];
    assign w_imm_i    = {{20{instruction[31]}}, instruction[31:20]};
    assign w_imm_s    = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign w_imm_b    = {{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
    assign w_imm_u    = {instruction[31:12], 12'h000};
    assign w_imm_j    = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
    assign w_pc_plus4 = r_pc + 32'd4;

    rv32i_register_file register_file_inst (
        .clk      (clk),
        .i_reset  (reset_n),
        .i_we     (w_rd_we),
        .i_waddr  (instruction[11:7]),
        .i_wdata  (w_rd_data),
        .i_raddr1 (instruction[19:15]),
        .i_raddr2 (instruction[24:20]),
        .o_rdata1 (w_rs1_val),
        .o_rdata2 (w_rs2_val)
    );

    // Shared adder: load/store address and JALR target before bit-0 clearing
    assign w_addr  = w_rs1_val + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);
    assign w_alu_b = (w_opcode == OP_REG) ? w_rs2_val : w_imm_i;
    assign w_sub   = (w_opcode == OP_REG) && w_f7[5];

    always_comb begin
        case (w_f3)
            3'b000:  w_alu = w_sub ? (w_rs1_val - w_alu_b) : (w_rs1_val + w_alu_b);
            3'b001:  w_alu = w_rs1_val << w_alu_b[4:0];
            3'b010:  w_alu = {31'b0, $signed(w_rs1_val) < $signed(w_alu_b)};
            3'b011:  w_alu = {31'b0, w_rs1_val < w_alu_b};
            3'b100:  w_alu = w_rs1_val ^ w_alu_b;
            3'b101:  w_alu = w_f7[5] ? 32'($signed(w_rs1_val) >>> w_alu_b[4:0])
                                     : (w_rs1_val >> w_alu_b[4:0]);
            3'b110:  w_alu = w_rs1_val | w_alu_b;
            default: w_alu = w_rs1_val & w_alu_b;
        endcase
    end

    always_comb begin
        if (w_opcode == OP_REG)
            w_arith_ok = (w_f7 == 7'h00) || ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
        else if (w_f3 == 3'b001)
            w_arith_ok = (w_f7 == 7'h00);
        else if (w_f3 == 3'b101)
            w_arith_ok = (w_f7 == 7'h00) || (w_f7 == 7'h20);
        else
            w_arith_ok = 1'b1;
    end

    always_comb begin
        case (w_f3)
            3'b000:  w_taken = (w_rs1_val == w_rs2_val);
            3'b001:  w_taken = (w_rs1_val != w_rs2_val);
            3'b100:  w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101:  w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110:  w_taken = (w_rs1_val <  w_rs2_val);
            3'b111:  w_taken = (w_rs1_val >= w_rs2_val);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_rd_we   = 1'b0;
        w_rd_data = w_alu;
        w_next_pc = w_pc_plus4;
        w_store   = 1'b0;
        case (w_opcode)
            OP_LUI:    begin w_rd_we = 1'b1; w_rd_data = w_imm_u; end
            OP_AUIPC:  begin w_rd_we = 1'b1; w_rd_data = r_pc + w_imm_u; end
            OP_JAL:    begin w_rd_we = 1'b1; w_rd_data = w_pc_plus4; w_next_pc = r_pc + w_imm_j; end
            OP_JALR:   if (w_f3 == 3'b000) begin
                           w_rd_we   = 1'b1;
                           w_rd_data = w_pc_plus4;
                           w_next_pc = w_addr & ~32'd1;
                       end
            OP_BRANCH: if (w_taken) w_next_pc = r_pc + w_imm_b;
            OP_LOAD:   if (w_f3 == 3'b010) begin w_rd_we = 1'b1; w_rd_data = mem_rd_data; end
            OP_STORE:  w_store = (w_f3 == 3'b010);
            OP_IMM, OP_REG: w_rd_we = w_arith_ok;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) r_pc <= RESET_PC;
        else         r_pc <= w_next_pc;
    end

    assign rom_addr    = r_pc;
    assign mem_addr    = w_addr;
    assign mem_wr_data = w_rs2_val;
    assign mem_wr_sig  = w_store & ~reset_n;
endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Bench for the single-cycle RV32I core: directed programs plus random programs,
// checked cycle by cycle against an instruction-level model via a scoreboard queue.

module tb_rv32i_single_cycle_core;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] instruction, mem_rd_data, mem_wr_data, mem_addr, rom_addr;
    logic        mem_wr_sig;

    logic [31:0] rom [0:63];
    logic [31:0] ram [0:255];

    always #5 clk = ~clk;

    assign instruction = rom[rom_addr[7:2]];
    assign mem_rd_data = ram[mem_addr[9:2]];

    rv32i_single_cycle_core #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instruction (instruction),
        .mem_rd_data (mem_rd_data),
        .mem_wr_sig  (mem_wr_sig),
        .mem_wr_data (mem_wr_data),
        .mem_addr    (mem_addr),
        .rom_addr    (rom_addr)
    );

    typedef struct {
        logic        chk_pc;
        logic [31:0] pc;
        logic        wr;
        logic        chk_mem;
        logic [31:0] addr;
        logic        chk_wd;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: architectural PC, registers and a private copy of data memory
    logic [31:0] m_pc;
    logic [31:0] m_regs [0:31];
    logic [31:0] m_ram  [0:255];
    logic        m_known = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.chk_pc) check("rom_addr", rom_addr, e.pc);
            check("mem_wr_sig", {31'b0, mem_wr_sig}, {31'b0, e.wr});
            if (e.chk_mem) check("mem_addr", mem_addr, e.addr);
            if (e.chk_wd)  check("mem_wr_data", mem_wr_data, e.wdata);
        end
    end

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [19:0] imm);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // Executes the instruction at m_pc, returns the outputs it must show, commits its effects
    task automatic model_exec(output exp_t e);
        logic [31:0] ins, a, b, imm_i, imm_s, imm_b, imm_u, imm_j, npc, res, addr;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic        wr_rd, taken, reg_op;
        ins   = rom[m_pc[7:2]];
        op    = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        a     = m_regs[ins[19:15]];
        b     = m_regs[ins[24:20]];
        imm_i = 32'($signed(ins[31:20]));
        imm_s = 32'($signed({ins[31:25], ins[11:7]}));
        imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        imm_u = {ins[31:12], 12'h000};
        imm_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        npc   = m_pc + 32'd4;
        wr_rd = 1'b0;
        res   = '0;
        e.chk_pc = 1'b1; e.pc = m_pc; e.wr = 1'b0; e.chk_mem = 1'b0; e.addr = '0;
        e.chk_wd = 1'b1; e.wdata = b;
        case (op)
            7'h37: begin wr_rd = 1'b1; res = imm_u; end
            7'h17: begin wr_rd = 1'b1; res = m_pc + imm_u; end
            7'h6F: begin wr_rd = 1'b1; res = m_pc + 32'd4; npc = m_pc + imm_j; end
            7'h67: if (f3 == 3'd0) begin wr_rd = 1'b1; res = m_pc + 32'd4; npc = (a + imm_i) & ~32'd1; end
            7'h63: begin
                case (f3)
                    3'd0: taken = (a == b);
                    3'd1: taken = (a != b);
                    3'd4: taken = ($signed(a) <  $signed(b));
                    3'd5: taken = ($signed(a) >= $signed(b));
                    3'd6: taken = (a <  b);
                    3'd7: taken = (a >= b);
                    default: taken = 1'b0;
                endcase
                if (taken) npc = m_pc + imm_b;
            end
            7'h03: if (f3 == 3'd2) begin
                addr = a + imm_i; e.chk_mem = 1'b1; e.addr = addr;
                wr_rd = 1'b1; res = m_ram[addr[9:2]];
            end
            7'h23: if (f3 == 3'd2) begin
                addr = a + imm_s; e.chk_mem = 1'b1; e.addr = addr; e.wr = 1'b1;
                m_ram[addr[9:2]] = b;
            end
            7'h13, 7'h33: begin
                reg_op = (op == 7'h33);
                if (!reg_op) b = imm_i;
                if (reg_op) wr_rd = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                else        wr_rd = (f3 == 3'd1) ? (f7 == 7'h00)
                                  : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                case (f3)
                    3'd0: res = (reg_op && f7 == 7'h20) ? a - b : a + b;
                    3'd1: res = a << b[4:0];
                    3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < b) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ b;
                    3'd5: res = (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                    3'd6: res = a | b;
                    default: res = a & b;
                endcase
            end
            default: ;
        endcase
        if (wr_rd && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
        m_pc = npc;
    endtask

    task automatic bench_edge();
        logic        wr;
        logic [31:0] a, d;
        @(negedge clk);
        wr = mem_wr_sig; a = mem_addr; d = mem_wr_data;
        @(posedge clk);
        #1;
        if (wr === 1'b1) ram[a[9:2]] = d;
    endtask

    task automatic cycle_reset();
        exp_t e;
        reset_n = 1'b1;
        e.chk_pc = m_known; e.pc = m_pc; e.wr = 1'b0; e.chk_mem = 1'b0; e.addr = '0;
        e.chk_wd = 1'b0; e.wdata = '0;
        sb_q.push_back(e);
        bench_edge();
        m_pc = RESET_PC;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_known = 1'b1;
    endtask

    task automatic cycle_run();
        exp_t e;
        reset_n = 1'b0;
        model_exec(e);
        sb_q.push_back(e);
        bench_edge();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle_run();
    endtask

    task automatic start(input logic [31:0] prog[$]);
        for (int i = 0; i < 64; i++) rom[i] = (i < prog.size()) ? prog[i] : NOP;
        for (int i = 0; i < 256; i++) begin ram[i] = $urandom; m_ram[i] = ram[i]; end
        cycle_reset();
        cycle_reset();
    endtask

    task automatic check_reg(input int idx, input logic [31:0] exp);
        check($sformatf("x%0d", idx), dut.register_file_inst.registers[idx], exp);
    endtask

    task automatic check_all_regs();
        for (int i = 0; i < 32; i++) check($sformatf("regfile x%0d", i), dut.register_file_inst.registers[i], m_regs[i]);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom);
        imm = 12'($urandom);
        case ($urandom_range(0, 11))
            0:  return enc_u(7'h37, rd, 20'($urandom));
            1:  return enc_u(7'h17, rd, 20'($urandom));
            2:  return enc_j(rd, 21'((int'($urandom_range(0, 31)) - 16) * 4));
            3:  return enc_i(7'h67, 3'd0, rd, rs1, imm);
            4:  begin
                    f3 = 3'($urandom_range(0, 5));
                    if (f3 >= 3'd2) f3 = f3 + 3'd2;
                    return enc_b(f3, rs1, rs2, 13'((int'($urandom_range(0, 31)) - 16) * 4));
                end
            5:  return enc_i(7'h03, 3'd2, rd, rs1, imm);
            6:  return enc_s(3'd2, rs1, rs2, imm);
            7, 11: begin
                    if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
                    if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
                    return enc_i(7'h13, f3, rd, rs1, imm);
                end
            8, 9: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                               f3, rd, rs1, rs2);
            default: begin
                case ($urandom_range(0, 6))
                    0: return 32'h0000_0000;
                    1: return 32'h0000_000F;
                    2: return 32'h0000_0073;
                    3: return 32'h0010_0073;
                    4: return enc_i(7'h03, 3'd0, rd, rs1, imm);
                    5: return enc_s(3'd1, rs1, rs2, imm);
                    default: return {$urandom_range(0, 32'h1FF_FFFF), 7'h7F};
                endcase
            end
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p[$];
        @(posedge clk);
        #1;

        // Reset with a ROM of NOPs, then sequential fetch
        p = {};
        start(p);
        check("reset rom_addr", rom_addr, 32'h0);
        check("reset mem_wr_sig", {31'b0, mem_wr_sig}, 32'h0);
        for (int i = 0; i < 32; i++) check_reg(i, 32'h0);
        run(1); check("step rom_addr 4", rom_addr, 32'h4);
        run(1); check("step rom_addr 8", rom_addr, 32'h8);

        p = {enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'(-5)), enc_i(7'h13, 3'd0, 5'd2, 5'd0, 12'd3),
             enc_r(7'h20, 3'd0, 5'd3, 5'd1, 5'd2), enc_r(7'h00, 3'd2, 5'd4, 5'd1, 5'd2),
             enc_r(7'h00, 3'd3, 5'd5, 5'd1, 5'd2), enc_i(7'h13, 3'd5, 5'd6, 5'd1, 12'h401),
             enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd7)};
        start(p); run(7);
        check_reg(3, 32'hFFFF_FFF8); check_reg(4, 32'h1); check_reg(5, 32'h0);
        check_reg(6, 32'hFFFF_FFFD); check_reg(0, 32'h0);
        check_all_regs();

        p = {enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'h040), enc_i(7'h13, 3'd0, 5'd2, 5'd0, 12'h123),
             enc_s(3'd2, 5'd1, 5'd2, 12'd4), enc_i(7'h03, 3'd2, 5'd3, 5'd1, 12'd4)};
        start(p); run(2);
        check("SW mem_wr_sig", {31'b0, mem_wr_sig}, 32'h1);
        check("SW mem_addr", mem_addr, 32'h44);
        check("SW mem_wr_data", mem_wr_data, 32'h123);
        run(2);
        check_reg(3, 32'h123);

        p = {enc_b(3'd0, 5'd0, 5'd0, 13'd8)};
        start(p); run(1); check("BEQ rom_addr", rom_addr, 32'h8);
        p = {enc_b(3'd1, 5'd0, 5'd0, 13'd8)};
        start(p); run(1); check("BNE rom_addr", rom_addr, 32'h4);
        p = {NOP, NOP, enc_j(5'd1, 21'd16)};
        start(p); run(3); check("JAL rom_addr", rom_addr, 32'd24); check_reg(1, 32'd12);
        p = {enc_i(7'h67, 3'd0, 5'd2, 5'd0, 12'd5)};
        start(p); run(1); check("JALR rom_addr", rom_addr, 32'h4); check_reg(2, 32'h4);

        p = {enc_u(7'h37, 5'd1, 20'hABCDE), enc_u(7'h17, 5'd2, 20'h00001)};
        start(p); run(2); check_reg(1, 32'hABCD_E000); check_reg(2, 32'h0000_1004);

        // Unsupported opcode as NOP, then reset mid-program
        p = {32'h0000_0000, enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd9)};
        start(p); run(1);
        check("illegal rom_addr", rom_addr, 32'h4);
        check_all_regs();
        run(3);
        cycle_reset();
        check("mid reset rom_addr", rom_addr, RESET_PC);
        run(1); check("restart rom_addr", rom_addr, 32'h4);

        for (int t = 0; t < 10; t++) begin
            p = {};
            for (int i = 0; i < 64; i++) p.push_back(rand_instr());
            start(p);
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 59) == 0) cycle_reset();
                else cycle_run();
            end
            check_all_regs();
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
